regfile_param: RTL and testbench
================================

# regfile_param

Parametrised multi-port integer register file with a pending-write scoreboard, used as the next-generation register file in the pipelined core. It provides NUM_RD combinational read ports and NUM_WR posedge write ports, with optional write-to-read bypass and a hardwired zero register. Per-register busy bits let the issue stage detect RAW/WAW hazards against writes still in flight.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W
- NUM_RD, 2, read ports (1..4)
- NUM_WR, 1, write ports (1..2)
- BYPASS, 1, 1 = same-cycle write data is forwarded to reads
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and issues

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  packed read indices; port i = bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data
- rd_busy  out  NUM_RD  read register has a pending write
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*ADDR_W  packed write indices
- wr_data  in  NUM_WR*DATA_W  packed write data
- iss_valid  in  1  issue stage reserves iss_rd as a pending destination
- iss_rd  in  ADDR_W  destination being reserved
- iss_ready  out  1  reservation accepted this cycle
- flush  in  1  synchronous clear of all busy bits
- pending_cnt  out  ADDR_W+1  number of set busy bits

## Operation
- Reset (reset = 0, asynchronous): all registers = 0, all busy bits = 0, pending_cnt = 0. Consequently rd_data = 0, rd_busy = 0, iss_ready = 1.
- Write: at posedge, for each port with wr_en[j], regs[wr_addr[j]] <= wr_data[j].
  - Same address on two ports in one cycle: higher port index wins.
  - If ZERO_REG, writes to index 0 are dropped.
- Read: combinational, rd_data[i] = regs[rd_addr[i]].
  - If BYPASS and some enabled write port targets rd_addr[i] this cycle, rd_data[i] = that port's wr_data (highest index wins).
  - If ZERO_REG and rd_addr[i] == 0, rd_data[i] = 0, overriding bypass.
- Scoreboard:
  - busy[r] clears at posedge when any wr_en targets r.
  - busy[r] sets at posedge on an accepted issue: iss_valid & iss_ready & !(ZERO_REG & iss_rd == 0) & !flush.
  - If a set and a clear target the same r in the same cycle, set wins.
- iss_ready = !busy[iss_rd]. Combinational, with no credit for a same-cycle clear, so WAW stalls one extra cycle.
- rd_busy[i] = busy[rd_addr[i]] & !(BYPASS & same-cycle write to rd_addr[i]). It is forced to 0 for index 0 when ZERO_REG.
- flush: at posedge, all busy bits clear. A concurrent issue is ignored; concurrent writes still update data.
- pending_cnt is a registered popcount of busy bits:
  - Updated incrementally: +1 on an accepted set, -1 per distinct cleared busy register.
  - Reset to 0 on flush.
  - It never exceeds NUM_REGS (or NUM_REGS-1 with ZERO_REG).

## Timing
- Read latency 0 (combinational from rd_addr and register state).
- Write latency 1: data is visible on non-bypassed reads the cycle after wr_en. With BYPASS, it is visible in the same cycle.
- Busy set and clear take effect the cycle after the triggering edge. iss_ready and rd_busy follow combinationally.
- Reset asserted mid-operation clears all state immediately, independent of clock. The first write is accepted on the first posedge after reset deasserts.

## Test plan
- Reset, then read all 32 registers on both ports -> every rd_data = 0, rd_busy = 0, iss_ready = 1, pending_cnt = 0.
- Write 0xDEADBEEF to r5 while reading r5 with BYPASS = 1 -> rd_data = 0xDEADBEEF in the same cycle. With BYPASS = 0 -> old value 0 that cycle, 0xDEADBEEF the next.
- NUM_WR = 2, both ports write r7 (0x11, 0x22) -> r7 = 0x22. Writing 0x33 to r0 -> r0 still reads 0.
- Issue r3 -> next cycle rd_busy = 1 on a port reading r3, iss_ready = 0 for iss_rd = 3, pending_cnt = 1. Write r3 -> busy clears, pending_cnt = 0.
- Issue r4, r6, r9 on consecutive cycles, then assert flush together with an issue of r10 -> all busy 0, pending_cnt = 0, r10 not busy.
- Assert reset mid-sequence, off-edge, with r8 = 0xAA and busy -> r8 = 0 and busy cleared immediately, before the next posedge.

Source files
------------

// File: rtl/regfile_param.sv
// Parametrised multi-port register file with a per-register pending-write scoreboard.
// Reads are combinational with optional same-cycle write forwarding; register 0 may be hardwired to zero.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       iss_valid,
  input  logic [ADDR_W-1:0]          iss_rd,
  output logic                       iss_ready,
  input  logic                       flush,
  output logic [ADDR_W:0]            pending_cnt
);

  localparam int NUM_REGS = 1 << ADDR_W;

  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] vec);
    logic [ADDR_W:0] cnt;
    cnt = {(ADDR_W+1){1'b0}};
    for (int k = 0; k < NUM_REGS; k++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, vec[k]};
    end
    return cnt;
  endfunction

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [NUM_REGS-1:0] busy_r;
  logic [ADDR_W:0]     cnt_r;

  logic [ADDR_W-1:0]   wa_s [NUM_WR];
  logic [DATA_W-1:0]   wd_s [NUM_WR];
  logic                we_s [NUM_WR];
  logic [NUM_REGS-1:0] clr_vec_s;
  logic [NUM_REGS-1:0] set_vec_s;
  logic [NUM_REGS-1:0] busy_nxt_s;
  logic [ADDR_W:0]     cnt_nxt_s;
  logic                iss_ready_s;
  logic                iss_acc_s;

  // Writes aimed at a hardwired zero register are filtered out here, so they neither store nor forward.
  for (genvar j = 0; j < NUM_WR; j++) begin : g_wr
    assign wa_s[j] = wr_addr[j*ADDR_W +: ADDR_W];
    assign wd_s[j] = wr_data[j*DATA_W +: DATA_W];
    assign we_s[j] = wr_en[j] & ~(ZERO_REG & (wa_s[j] == {ADDR_W{1'b0}}));
  end

  // Register storage; the higher-index port lands last and so wins an address collision.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_r[r] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (we_s[j]) begin
          regs_r[wa_s[j]] <= wd_s[j];
        end
      end
    end
  end

  // No credit for a same-cycle clear: a WAW reservation waits until the busy bit has actually dropped.
  assign iss_ready_s = ~busy_r[iss_rd];
  assign iss_acc_s   = iss_valid & iss_ready_s & ~flush
                       & ~(ZERO_REG & (iss_rd == {ADDR_W{1'b0}}));
  assign iss_ready   = iss_ready_s;

  // Next-state scoreboard: set beats clear on the same register, flush beats everything.
  always_comb begin
    clr_vec_s = {NUM_REGS{1'b0}};
    for (int j = 0; j < NUM_WR; j++) begin
      clr_vec_s[wa_s[j]] = clr_vec_s[wa_s[j]] | we_s[j];
    end
    set_vec_s         = {NUM_REGS{1'b0}};
    set_vec_s[iss_rd] = iss_acc_s;
    if (flush) begin
      busy_nxt_s = {NUM_REGS{1'b0}};
      cnt_nxt_s  = {(ADDR_W+1){1'b0}};
    end else begin
      busy_nxt_s = (busy_r & ~clr_vec_s) | set_vec_s;
      cnt_nxt_s  = cnt_r + {{ADDR_W{1'b0}}, iss_acc_s}
                   - popcount(busy_r & clr_vec_s & ~set_vec_s);
    end
  end

  // Busy bits and their running count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_r <= {NUM_REGS{1'b0}};
      cnt_r  <= {(ADDR_W+1){1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign pending_cnt = cnt_r;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] rdat_s;
    logic              hit_s;
    logic              zero_s;

    assign ra_s   = rd_addr[i*ADDR_W +: ADDR_W];
    assign zero_s = ZERO_REG & (ra_s == {ADDR_W{1'b0}});

    // Forwarding scan; later ports override earlier matches so the highest index wins.
    always_comb begin
      rdat_s = regs_r[ra_s];
      hit_s  = 1'b0;
      for (int j = 0; j < NUM_WR; j++) begin
        if (BYPASS && we_s[j] && (wa_s[j] == ra_s)) begin
          rdat_s = wd_s[j];
          hit_s  = 1'b1;
        end else begin
          rdat_s = rdat_s;
          hit_s  = hit_s;
        end
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = zero_s ? {DATA_W{1'b0}} : rdat_s;
    assign rd_busy[i]                  = busy_r[ra_s] & ~hit_s & ~zero_s;
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a default instance (bypass, one write port)
// and a second instance with two write ports and no bypass.
module tb_regfile_param;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset;

  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic [0:0]  a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_iss_valid;
  logic [4:0]  a_iss_rd;
  logic        a_iss_ready;
  logic        a_flush;
  logic [5:0]  a_pending;

  logic [9:0]  b_rd_addr;
  logic [63:0] b_rd_data;
  logic [1:0]  b_rd_busy;
  logic [1:0]  b_wr_en;
  logic [9:0]  b_wr_addr;
  logic [63:0] b_wr_data;
  logic        b_iss_valid;
  logic [4:0]  b_iss_rd;
  logic        b_iss_ready;
  logic        b_flush;
  logic [5:0]  b_pending;

  int tests = 0;
  int fails = 0;

  regfile_param dut_a (
    .clock(clock), .reset(reset),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .iss_valid(a_iss_valid), .iss_rd(a_iss_rd), .iss_ready(a_iss_ready),
    .flush(a_flush), .pending_cnt(a_pending)
  );

  regfile_param #(.NUM_WR(2), .BYPASS(1'b0)) dut_b (
    .clock(clock), .reset(reset),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .iss_valid(b_iss_valid), .iss_rd(b_iss_rd), .iss_ready(b_iss_ready),
    .flush(b_flush), .pending_cnt(b_pending)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    a_rd_addr   = 10'd0;  a_wr_en = 1'b0;  a_wr_addr = 5'd0;  a_wr_data = 32'd0;
    a_iss_valid = 1'b0;   a_iss_rd = 5'd0; a_flush = 1'b0;
    b_rd_addr   = {5'd7, 5'd7}; b_wr_en = 2'b00; b_wr_addr = 10'd0; b_wr_data = 64'd0;
    b_iss_valid = 1'b0;   b_iss_rd = 5'd0; b_flush = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_pending_a", 32'(a_pending), 32'd0);
    check("rst_pending_b", 32'(b_pending), 32'd0);
    check("rst_ready_b",   32'(b_iss_ready), 32'd1);
    check("rst_busy_b",    32'(b_rd_busy), 32'd0);
    #3 reset = 1'b1;
    #1;

    // every register reads zero and idle on both ports
    for (int r = 0; r < 32; r++) begin
      a_rd_addr = {5'(31 - r), 5'(r)};
      #1;
      check($sformatf("rst_rd0_r%0d", r), a_rd_data[31:0],  32'd0);
      check($sformatf("rst_rd1_r%0d", 31 - r), a_rd_data[63:32], 32'd0);
      check($sformatf("rst_busy_r%0d", r), 32'(a_rd_busy), 32'd0);
    end
    check("rst_ready_a", 32'(a_iss_ready), 32'd1);
    check("rst_b_r7",    b_rd_data[31:0], 32'd0);

    // same-cycle forwarding with and without bypass
    tick();
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF; a_rd_addr = {5'd0, 5'd5};
    b_wr_en = 2'b01; b_wr_addr = {5'd0, 5'd5}; b_wr_data = {32'h0, 32'hDEADBEEF};
    b_rd_addr = {5'd0, 5'd5};
    #1;
    check("byp_same",     a_rd_data[31:0],  32'hDEADBEEF);
    check("byp_r0",       a_rd_data[63:32], 32'd0);
    check("nobyp_same",   b_rd_data[31:0],  32'd0);
    tick();
    a_wr_en = 1'b0; b_wr_en = 2'b00;
    #1;
    check("byp_next",     a_rd_data[31:0], 32'hDEADBEEF);
    check("nobyp_next",   b_rd_data[31:0], 32'hDEADBEEF);

    // dual-port collision and writes to the zero register
    b_wr_en = 2'b11; b_wr_addr = {5'd7, 5'd7}; b_wr_data = {32'h22, 32'h11};
    b_rd_addr = {5'd7, 5'd7};
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h33; a_rd_addr = {5'd0, 5'd0};
    #1;
    check("coll_same_old", b_rd_data[31:0], 32'd0);
    check("zero_byp",      a_rd_data[31:0], 32'd0);
    tick();
    a_wr_en = 1'b0; b_wr_en = 2'b00;
    #1;
    check("coll_p0",  b_rd_data[31:0],  32'h22);
    check("coll_p1",  b_rd_data[63:32], 32'h22);
    check("zero_wr",  a_rd_data[31:0],  32'd0);
    check("zero_pend", 32'(a_pending), 32'd0);

    // issue r3, then retire it with a write
    a_iss_valid = 1'b1; a_iss_rd = 5'd3; a_rd_addr = {5'd3, 5'd5};
    #1;
    check("iss3_ready_pre", 32'(a_iss_ready), 32'd1);
    tick();
    a_iss_valid = 1'b0;
    #1;
    check("iss3_busy",    32'(a_rd_busy), 32'b10);
    check("iss3_ready",   32'(a_iss_ready), 32'd0);
    check("iss3_pending", 32'(a_pending), 32'd1);
    a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h1234;
    #1;
    check("wr3_byp_busy",  32'(a_rd_busy), 32'b00);
    check("wr3_nocredit",  32'(a_iss_ready), 32'd0);
    check("wr3_byp_data",  a_rd_data[63:32], 32'h1234);
    tick();
    a_wr_en = 1'b0;
    #1;
    check("wr3_busy",    32'(a_rd_busy), 32'b00);
    check("wr3_pending", 32'(a_pending), 32'd0);
    check("wr3_ready",   32'(a_iss_ready), 32'd1);

    // set beats a same-cycle clear, then a WAW issue stalls
    a_iss_valid = 1'b1; a_iss_rd = 5'd13;
    a_wr_en = 1'b1; a_wr_addr = 5'd13; a_wr_data = 32'h77;
    tick();
    a_iss_valid = 1'b0; a_wr_en = 1'b0; a_rd_addr = {5'd13, 5'd13};
    #1;
    check("setwin_busy",    32'(a_rd_busy), 32'b11);
    check("setwin_pending", 32'(a_pending), 32'd1);
    check("setwin_data",    a_rd_data[31:0], 32'h77);
    a_wr_en = 1'b1; a_wr_addr = 5'd13; a_wr_data = 32'h78;
    a_iss_valid = 1'b1; a_iss_rd = 5'd13;
    #1;
    check("waw_ready", 32'(a_iss_ready), 32'd0);
    tick();
    a_wr_en = 1'b0; a_iss_valid = 1'b0;
    #1;
    check("waw_busy",    32'(a_rd_busy), 32'b00);
    check("waw_pending", 32'(a_pending), 32'd0);

    // issuing r0 reserves nothing
    a_iss_valid = 1'b1; a_iss_rd = 5'd0;
    #1;
    check("iss0_ready", 32'(a_iss_ready), 32'd1);
    tick();
    a_iss_valid = 1'b0;
    #1;
    check("iss0_pending", 32'(a_pending), 32'd0);

    // three reservations then a flush with a concurrent issue
    a_iss_valid = 1'b1; a_iss_rd = 5'd4;
    tick();
    a_iss_rd = 5'd6;
    tick();
    a_iss_rd = 5'd9;
    tick();
    a_iss_rd = 5'd10; a_flush = 1'b1; a_rd_addr = {5'd9, 5'd4};
    #1;
    check("pre_flush_pending", 32'(a_pending), 32'd3);
    check("pre_flush_busy",    32'(a_rd_busy), 32'b11);
    tick();
    a_iss_valid = 1'b0; a_flush = 1'b0;
    #1;
    check("flush_pending", 32'(a_pending), 32'd0);
    check("flush_busy94",  32'(a_rd_busy), 32'b00);
    check("flush_ready10", 32'(a_iss_ready), 32'd1);
    a_rd_addr = {5'd10, 5'd6};
    #1;
    check("flush_busy106", 32'(a_rd_busy), 32'b00);

    // asynchronous reset in the middle of a cycle
    a_wr_en = 1'b1; a_wr_addr = 5'd8; a_wr_data = 32'hAA;
    tick();
    a_wr_en = 1'b0; a_iss_valid = 1'b1; a_iss_rd = 5'd8;
    tick();
    a_iss_valid = 1'b0; a_rd_addr = {5'd8, 5'd8};
    #1;
    check("pre_rst_data",    a_rd_data[31:0], 32'hAA);
    check("pre_rst_busy",    32'(a_rd_busy), 32'b11);
    check("pre_rst_pending", 32'(a_pending), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("arst_data",    a_rd_data[31:0], 32'd0);
    check("arst_busy",    32'(a_rd_busy), 32'b00);
    check("arst_pending", 32'(a_pending), 32'd0);
    check("arst_ready",   32'(a_iss_ready), 32'd1);
    check("arst_b_r7",    b_rd_data[31:0], 32'd0);
    #2 reset = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 5'd8; a_wr_data = 32'h55;
    tick();
    a_wr_en = 1'b0;
    #1;
    check("post_rst_wr", a_rd_data[31:0], 32'h55);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
